dino_motion_ctrl: RTL and testbench

Frame-rate sequencer for the T-rex sprite and game lifecycle. Sits between the button/switch inputs and the VGA sprite renderer. Consumes a once-per-frame tick, jump/duck levels and the collision flag from the obstacle datapath. Produces the dino's vertical position, pose code, game state, score-advance pulses and buzzer trigger pulses.

---
 rtl/dino_pkg.sv | 41 ++++
 rtl/dino_frame_div.sv | 29 ++
 rtl/dino_motion_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dino_motion_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types for the dino sequencer: lifecycle states, pose codes, default tuning constants.
// Pure declarations; no timing or flow control.
package dino_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RUN  = 3'd1,
      AIR  = 3'd2,
      DUCK = 3'd3,
      DEAD = 3'd4
   } dino_state_t;

   localparam logic [2:0] IDLE_P = 3'd0;
   localparam logic [2:0] RUN_A  = 3'd1;
   localparam logic [2:0] RUN_B  = 3'd2;
   localparam logic [2:0] DUCK_A = 3'd3;
   localparam logic [2:0] DUCK_B = 3'd4;
   localparam logic [2:0] AIR_P  = 3'd5;
   localparam logic [2:0] DEAD_P = 3'd6;

   localparam int DEF_GROUND_Y    = 300;
   localparam int DEF_JUMP_V0     = 12;
   localparam int DEF_GRAVITY     = 1;
   localparam int DEF_ANIM_DIV    = 6;
   localparam int DEF_SCORE_DIV   = 4;
   localparam int DEF_DEAD_FRAMES = 60;

   function automatic logic [2:0] pose_of(input dino_state_t s, input logic leg);
      logic [2:0] p;
      p = IDLE_P;
      case (s)
         RUN:     p = leg ? RUN_B : RUN_A;
         DUCK:    p = leg ? DUCK_B : DUCK_A;
         AIR:     p = AIR_P;
         DEAD:    p = DEAD_P;
         default: p = IDLE_P;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/dino_frame_div.sv
// Generic frame_tick divider: counts enabled ticks, wraps at DIV-1 with a combinational wrap pulse.
// Wrap is valid in the cycle the last tick is enabled; clear has priority; no backpressure.
module dino_frame_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic wrap
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] cnt_q;

   assign wrap = en & (cnt_q == W'(DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr || wrap) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

endmodule

// File: rtl/dino_motion_ctrl.sv
// T-rex motion and game-lifecycle sequencer; define FAST_FALL_EN for 3x gravity while ducking in the air.
// All outputs registered, updated 1 cycle after frame_tick/collide is sampled; tick-driven, no backpressure.
module dino_motion_ctrl
   import dino_pkg::*;
#(
   parameter int GROUND_Y    = DEF_GROUND_Y,
   parameter int JUMP_V0     = DEF_JUMP_V0,
   parameter int GRAVITY     = DEF_GRAVITY,
   parameter int ANIM_DIV    = DEF_ANIM_DIV,
   parameter int SCORE_DIV   = DEF_SCORE_DIV,
   parameter int DEAD_FRAMES = DEF_DEAD_FRAMES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       jump,
   input  logic       duck,
   input  logic       collide,
   output logic [9:0] dino_y,
   output logic [2:0] pose,
   output logic [2:0] state,
   output logic       score_tick,
   output logic       snd_jump,
   output logic       snd_dead
);

   localparam int DW = $clog2(DEAD_FRAMES + 1);

   dino_state_t        st_q, st_d;
   logic [9:0]         height_q, height_d;
   logic signed [7:0]  vel_q, vel_d, fall;
   logic [DW-1:0]      dead_q, dead_d;
   logic               jump_prev_q, jump_req_q, jump_req_d, jump_rise;
   logic               leg_q, leg_d;
   logic               snd_jump_d, snd_dead_d, restart;
   logic               active, anim_en, score_en, anim_wrap, score_wrap;
   logic signed [10:0] air_next;

   assign jump_rise = jump & ~jump_prev_q;
   assign active    = (st_q == RUN) || (st_q == AIR) || (st_q == DUCK);
   // A collision edge suppresses both counters so no score_tick leaks out on the death edge.
   assign score_en  = frame_tick & active & ~collide;
   assign anim_en   = frame_tick & ((st_q == RUN) || (st_q == DUCK)) & ~collide;
   assign air_next  = $signed({1'b0, height_q}) + $signed({{3{vel_q[7]}}, vel_q});

`ifdef FAST_FALL_EN
   assign fall = duck ? 8'(3 * GRAVITY) : 8'(GRAVITY);
`else
   assign fall = 8'(GRAVITY);
`endif

   always_comb begin
      st_d       = st_q;
      height_d   = height_q;
      vel_d      = vel_q;
      dead_d     = dead_q;
      snd_jump_d = 1'b0;
      snd_dead_d = 1'b0;
      restart    = 1'b0;
      case (st_q)
         IDLE: begin
            if (frame_tick && jump_req_q) begin
               st_d     = RUN;
               height_d = '0;
            end
         end
         RUN, DUCK: begin
            if (collide) begin
               st_d       = DEAD;
               snd_dead_d = 1'b1;
               dead_d     = '0;
            end else if (frame_tick) begin
               if (jump_req_q) begin
                  st_d       = AIR;
                  vel_d      = 8'(JUMP_V0);
                  snd_jump_d = 1'b1;
               end else begin
                  st_d = duck ? DUCK : RUN;
               end
            end
         end
         AIR: begin
            if (collide) begin
               st_d       = DEAD;
               snd_dead_d = 1'b1;
               dead_d     = '0;
            end else if (frame_tick) begin
               if (air_next <= 11'sd0) begin
                  height_d = '0;
                  vel_d    = '0;
                  st_d     = duck ? DUCK : RUN;
               end else begin
                  height_d = air_next[9:0];
                  vel_d    = vel_q - fall;
               end
            end
         end
         DEAD: begin
            if (frame_tick) begin
               if (jump_req_q && (dead_q == DW'(DEAD_FRAMES))) begin
                  st_d     = IDLE;
                  height_d = '0;
                  vel_d    = '0;
                  restart  = 1'b1;
               end else if (dead_q != DW'(DEAD_FRAMES)) begin
                  dead_d = dead_q + DW'(1);
               end
            end
         end
         default: st_d = IDLE;
      endcase
      // A request lives for at most one frame; a fresh press wins over the frame that consumes the old one.
      jump_req_d = jump_rise | (jump_req_q & ~frame_tick & (st_d == st_q));
      leg_d      = restart ? 1'b0 : (leg_q ^ anim_wrap);
   end

   dino_frame_div #(.DIV(ANIM_DIV)) u_anim_div (
      .clk  (clk),
      .rst  (rst),
      .clr  (restart),
      .en   (anim_en),
      .wrap (anim_wrap)
   );

   dino_frame_div #(.DIV(SCORE_DIV)) u_score_div (
      .clk  (clk),
      .rst  (rst),
      .clr  (restart),
      .en   (score_en),
      .wrap (score_wrap)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q        <= IDLE;
         height_q    <= '0;
         vel_q       <= '0;
         dead_q      <= '0;
         jump_prev_q <= 1'b0;
         jump_req_q  <= 1'b0;
         leg_q       <= 1'b0;
         dino_y      <= 10'(GROUND_Y);
         pose        <= IDLE_P;
         score_tick  <= 1'b0;
         snd_jump    <= 1'b0;
         snd_dead    <= 1'b0;
      end else begin
         st_q        <= st_d;
         height_q    <= height_d;
         vel_q       <= vel_d;
         dead_q      <= dead_d;
         jump_prev_q <= jump;
         jump_req_q  <= jump_req_d;
         leg_q       <= leg_d;
         dino_y      <= 10'(GROUND_Y) - height_d;
         pose        <= pose_of(st_d, leg_d);
         score_tick  <= score_wrap;
         snd_jump    <= snd_jump_d;
         snd_dead    <= snd_dead_d;
      end
   end

   assign state = st_q;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Scoreboard bench for dino_motion_ctrl: expected outputs queued per driven cycle, compared after the edge.
module tb_dino_motion_ctrl;
   import dino_pkg::*;

   localparam int T_GROUND_Y  = 300;
   localparam int T_JUMP_V0   = 12;
   localparam int T_ANIM_DIV  = 6;
   localparam int T_SCORE_DIV = 4;
`ifdef FAST_FALL_EN
   localparam int T_FALL_DUCK = 3;
`else
   localparam int T_FALL_DUCK = 1;
`endif

   logic clk = 1'b0;
   logic rst, frame_tick, jump, duck, collide;
   logic [9:0] dino_y;
   logic [2:0] pose, state;
   logic score_tick, snd_jump, snd_dead;

   dino_motion_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .jump       (jump),
      .duck       (duck),
      .collide    (collide),
      .dino_y     (dino_y),
      .pose       (pose),
      .state      (state),
      .score_tick (score_tick),
      .snd_jump   (snd_jump),
      .snd_dead   (snd_dead)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] st;
      logic [9:0] y;
      logic [2:0] pose;
      logic       sc;
      logic       sj;
      logic       sd;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   sc_n, an_n, eh, ev;
   logic leg;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, expv);
      end
   endtask

   task automatic compare_out(input string tag);
      exp_t x;
      x = exp_q.pop_front();
      check({tag, ".state"}, 32'(state), 32'(x.st));
      check({tag, ".dino_y"}, 32'(dino_y), 32'(x.y));
      check({tag, ".pose"}, 32'(pose), 32'(x.pose));
      check({tag, ".score_tick"}, 32'(score_tick), 32'(x.sc));
      check({tag, ".snd_jump"}, 32'(snd_jump), 32'(x.sj));
      check({tag, ".snd_dead"}, 32'(snd_dead), 32'(x.sd));
   endtask

   task automatic step(input string tag, input logic ft, input logic c);
      @(negedge clk);
      frame_tick = ft;
      collide    = c;
      exp_q.push_back(e);
      e.sc = 1'b0;
      e.sj = 1'b0;
      e.sd = 1'b0;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      collide    = 1'b0;
      compare_out(tag);
   endtask

   function automatic logic [2:0] run_pose(input logic dk);
      if (dk) return leg ? DUCK_B : DUCK_A;
      return leg ? RUN_B : RUN_A;
   endfunction

   task automatic set_reset_exp();
      e.st = IDLE; e.y = 10'(T_GROUND_Y); e.pose = IDLE_P;
      e.sc = 1'b0; e.sj = 1'b0; e.sd = 1'b0;
      sc_n = 0; an_n = 0; leg = 1'b0; eh = 0; ev = 0;
   endtask

   // Frame taken in RUN/AIR/DUCK: advances score (and leg animation when on the ground).
   task automatic count_tick(input logic anim);
      sc_n++;
      if (sc_n == T_SCORE_DIV) begin sc_n = 0; e.sc = 1'b1; end
      if (anim) begin
         an_n++;
         if (an_n == T_ANIM_DIV) begin an_n = 0; leg = ~leg; end
      end
   endtask

   task automatic press_jump();
      jump = 1'b1;
      step("press", 1'b0, 1'b0);
      jump = 1'b0;
   endtask

   task automatic run_tick(input logic dk, output logic obs);
      duck = dk;
      count_tick(1'b1);
      e.st = dk ? DUCK : RUN;
      e.pose = run_pose(dk);
      e.y = 10'(T_GROUND_Y);
      step("run", 1'b1, 1'b0);
      obs = score_tick;
      step("run_gap", 1'b0, 1'b0);
   endtask

   task automatic launch();
      press_jump();
      count_tick(1'b1);
      e.st = AIR; e.pose = AIR_P; e.sj = 1'b1;
      eh = 0; ev = T_JUMP_V0;
      step("launch", 1'b1, 1'b0);
      step("launch_gap", 1'b0, 1'b0);
   endtask

   task automatic air_tick(output logic landed);
      int nh;
      count_tick(1'b0);
      nh = eh + ev;
      landed = 1'b0;
      if (nh <= 0) begin
         eh = 0; ev = 0; landed = 1'b1;
         e.st = duck ? DUCK : RUN;
         e.pose = run_pose(duck);
      end else begin
         eh = nh;
         ev = ev - (duck ? T_FALL_DUCK : 1);
      end
      e.y = 10'(T_GROUND_Y - eh);
      step("air", 1'b1, 1'b0);
      step("air_gap", 1'b0, 1'b0);
   endtask

   initial begin
      logic landed, obs;
      int   n, sct;
      rst = 1'b1; jump = 1'b0; duck = 1'b0; frame_tick = 1'b0; collide = 1'b0;
      set_reset_exp();
      step("reset", 1'b0, 1'b0);
      step("reset_tick", 1'b1, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step("idle_tick", 1'b1, 1'b0);
         step("idle_gap", 1'b0, 1'b0);
      end

      // Start, then a full jump arc back to the ground.
      press_jump();
      e.st = RUN; e.pose = RUN_A;
      step("start", 1'b1, 1'b0);
      step("start_gap", 1'b0, 1'b0);
      launch();
      n = 0; landed = 1'b0;
      while (!landed && n < 40) begin air_tick(landed); n++; end
      check("air_frames", 32'(n), 32'd25);

      // Collision mid-air between ticks, then the death hold-off.
      launch();
      for (int i = 0; i < 5; i++) air_tick(landed);
      e.st = DEAD; e.pose = DEAD_P; e.sd = 1'b1;
      step("collide_air", 1'b0, 1'b1);
      step("dead_gap", 1'b0, 1'b0);
      for (int i = 0; i < 30; i++) begin step("dead_tick", 1'b1, 1'b0); step("dead_gap", 1'b0, 1'b0); end
      press_jump();
      step("dead_early_jump", 1'b1, 1'b0);
      for (int i = 0; i < 30; i++) begin step("dead_tick", 1'b1, 1'b0); step("dead_gap", 1'b0, 1'b0); end
      press_jump();
      set_reset_exp();
      step("restart", 1'b1, 1'b0);
      step("restart_gap", 1'b0, 1'b0);

      // 24 running frames: 6 score ticks, leg toggles every 6 frames.
      press_jump();
      e.st = RUN; e.pose = RUN_A;
      step("start2", 1'b1, 1'b0);
      sct = 0;
      for (int i = 0; i < 24; i++) begin run_tick(1'b0, obs); sct += int'(obs); end
      check("score_ticks_24", 32'(sct), 32'd6);
      for (int i = 0; i < 6; i++) run_tick(1'b1, obs);
      run_tick(1'b0, obs);

      // Duck pressed at the apex.
      launch();
      for (int i = 0; i < 12; i++) air_tick(landed);
      duck = 1'b1;
      n = 12; landed = 1'b0;
      while (!landed && n < 40) begin air_tick(landed); n++; end
`ifdef FAST_FALL_EN
      check("fast_fall_shorter", 32'(n < 25), 32'd1);
`else
      check("duck_air_frames", 32'(n), 32'd25);
`endif
      check("land_into_duck", 32'(state), 32'(DUCK));
      run_tick(1'b0, obs);

      // Collide on the same edge as a frame that would have wrapped the score counter.
      for (int i = 0; i < 8; i++) if (sc_n != T_SCORE_DIV - 1) run_tick(1'b0, obs);
      e.st = DEAD; e.pose = DEAD_P; e.sd = 1'b1;
      step("collide_tick", 1'b1, 1'b1);
      step("collide_gap", 1'b0, 1'b0);

      // Asynchronous reset in the middle of a jump.
      rst = 1'b1;
      set_reset_exp();
      step("rst_pulse", 1'b0, 1'b0);
      rst = 1'b0;
      press_jump();
      e.st = RUN; e.pose = RUN_A;
      step("start3", 1'b1, 1'b0);
      launch();
      for (int i = 0; i < 3; i++) air_tick(landed);
      check("pre_rst_y", 32'(dino_y), 32'd267);
      #3;
      rst = 1'b1;
      #1;
      set_reset_exp();
      exp_q.push_back(e);
      compare_out("async_rst");
      @(negedge clk);
      rst = 1'b0;
      step("post_rst", 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
